// File: rtl/mc_cmd_pkg.sv
// ============================================================================
// mc_cmd_pkg : shared command encodings, widths and timing defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package mc_cmd_pkg;

   localparam int DEF_RA    = 16;
   localparam int DEF_CA    = 10;
   localparam int DEF_DQ    = 16;
   localparam int DEF_IDX   = 6;
   localparam int NUM_BANKS = 16;
   localparam int BANK_W    = 4;

   localparam int DEF_T_RP  = 3;
   localparam int DEF_T_RCD = 3;
   localparam int DEF_T_CCD = 2;
   localparam int DEF_T_WTR = 4;

   typedef enum logic [2:0] {
      CMD_NOP = 3'd0,
      CMD_ACT = 3'd1,
      CMD_PRE = 3'd2,
      CMD_RD  = 3'd3,
      CMD_WR  = 3'd4
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_ACT  = 2'd2,
      ST_RW   = 2'd3
   } sched_state_t;

   typedef enum logic [1:0] {
      LK_CLOSED = 2'd0,
      LK_HIT    = 2'd1,
      LK_MISS   = 2'd2
   } lookup_t;

endpackage

`default_nettype wire

// File: rtl/bank_row_table.sv
// ============================================================================
// bank_row_table : per-bank open-row tracking with combinational lookup
// Rev 1.0
// ============================================================================
`default_nettype none

module bank_row_table
   import mc_cmd_pkg::*;
#(
   parameter int RA = DEF_RA
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BANK_W-1:0] lk_bank_i,
   input  logic [RA-1:0]     lk_row_i,
   output lookup_t           lk_res_o,
   input  logic              wr_open_i,
   input  logic              wr_close_i,
   input  logic [BANK_W-1:0] wr_bank_i,
   input  logic [RA-1:0]     wr_row_i
);

   logic [NUM_BANKS-1:0] valid_q;
   logic [RA-1:0]        row_q [NUM_BANKS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         row_q   <= '{default: '0};
      end else if (wr_open_i) begin
         valid_q[wr_bank_i] <= 1'b1;
         row_q[wr_bank_i]   <= wr_row_i;
      end else if (wr_close_i) begin
         valid_q[wr_bank_i] <= 1'b0;
      end
   end

   always_comb begin
      lk_res_o = LK_CLOSED;
      if (valid_q[lk_bank_i]) begin
         lk_res_o = (row_q[lk_bank_i] == lk_row_i) ? LK_HIT : LK_MISS;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bank_cmd_scheduler.sv
// ============================================================================
// bank_cmd_scheduler : one-request PRE/ACT/RD/WR sequencer with tRP/tRCD/tCCD/tWTR
// Rev 1.0
// ============================================================================
`default_nettype none

module bank_cmd_scheduler
   import mc_cmd_pkg::*;
#(
   parameter int RA    = DEF_RA,
   parameter int CA    = DEF_CA,
   parameter int DQ    = DEF_DQ,
   parameter int IDX   = DEF_IDX,
   parameter int T_RP  = DEF_T_RP,
   parameter int T_RCD = DEF_T_RCD,
   parameter int T_CCD = DEF_T_CCD,
   parameter int T_WTR = DEF_T_WTR
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           wr_en,
   output logic           ready,
   input  logic [DQ-1:0]  data_i,
   input  logic [IDX-1:0] idx_i,
   input  logic [RA-1:0]  row_i,
   input  logic [CA-1:0]  col_i,
   input  logic           t_i,
   input  logic [1:0]     ba_i,
   input  logic [1:0]     bg_i,
   output logic [2:0]     cmd_o,
   output logic [1:0]     cmd_ba_o,
   output logic [1:0]     cmd_bg_o,
   output logic [RA-1:0]  addr_o,
   output logic [DQ-1:0]  data_o,
   output logic [IDX-1:0] idx_o
);

   localparam logic [3:0] c_trp_ld  = 4'(T_RP - 1);
   localparam logic [3:0] c_trcd_ld = 4'(T_RCD - 1);
   localparam logic [3:0] c_tccd_ld = 4'(T_CCD - 1);
   localparam logic [3:0] c_twtr_ld = 4'(T_WTR - 1);

   sched_state_t state_q, state_d;
   logic [3:0]   trp_q, trp_d, trcd_q, trcd_d, tccd_q, tccd_d, twtr_q, twtr_d;

   logic [RA-1:0]     req_row_q;
   logic [CA-1:0]     req_col_q;
   logic [DQ-1:0]     req_data_q;
   logic [IDX-1:0]    req_idx_q;
   logic              req_t_q;
   logic [BANK_W-1:0] req_bank_q;

   cmd_t              cmd_q, cmd_d;
   logic [BANK_W-1:0] bank_q, bank_d;
   logic [RA-1:0]     addr_q, addr_d;
   logic [DQ-1:0]     data_q, data_d;
   logic [IDX-1:0]    idx_q, idx_d;

   lookup_t w_lk_res;
   logic    w_accept, w_tbl_open, w_tbl_close;

   assign ready    = (state_q == ST_IDLE);
   assign w_accept = wr_en && ready;

   bank_row_table #(.RA(RA)) u_table (
      .clk        (clk),
      .rst_n      (rst_n),
      .lk_bank_i  ({bg_i, ba_i}),
      .lk_row_i   (row_i),
      .lk_res_o   (w_lk_res),
      .wr_open_i  (w_tbl_open),
      .wr_close_i (w_tbl_close),
      .wr_bank_i  (req_bank_q),
      .wr_row_i   (req_row_q)
   );

   always_comb begin
      state_d     = state_q;
      cmd_d       = CMD_NOP;
      bank_d      = '0;
      addr_d      = '0;
      data_d      = '0;
      idx_d       = '0;
      w_tbl_open  = 1'b0;
      w_tbl_close = 1'b0;
      trp_d       = (trp_q  != 4'd0) ? trp_q  - 4'd1 : 4'd0;
      trcd_d      = (trcd_q != 4'd0) ? trcd_q - 4'd1 : 4'd0;
      tccd_d      = (tccd_q != 4'd0) ? tccd_q - 4'd1 : 4'd0;
      twtr_d      = (twtr_q != 4'd0) ? twtr_q - 4'd1 : 4'd0;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               case (w_lk_res)
                  LK_HIT:  state_d = ST_RW;
                  LK_MISS: state_d = ST_PRE;
                  default: state_d = ST_ACT;
               endcase
            end
         end
         // PRE waits on tCCD so it never truncates the previous burst.
         ST_PRE: begin
            if (tccd_q == 4'd0) begin
               cmd_d       = CMD_PRE;
               bank_d      = req_bank_q;
               w_tbl_close = 1'b1;
               trp_d       = c_trp_ld;
               state_d     = ST_ACT;
            end
         end
         ST_ACT: begin
            if (trp_q == 4'd0) begin
               cmd_d      = CMD_ACT;
               bank_d     = req_bank_q;
               addr_d     = req_row_q;
               w_tbl_open = 1'b1;
               trcd_d     = c_trcd_ld;
               state_d    = ST_RW;
            end
         end
         ST_RW: begin
            if (trcd_q == 4'd0 && tccd_q == 4'd0 && (req_t_q || twtr_q == 4'd0)) begin
               cmd_d   = req_t_q ? CMD_WR : CMD_RD;
               bank_d  = req_bank_q;
               addr_d  = RA'(req_col_q);
               data_d  = req_t_q ? req_data_q : '0;
               idx_d   = req_idx_q;
               tccd_d  = c_tccd_ld;
               if (req_t_q) begin
                  twtr_d = c_twtr_ld;
               end
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         trp_q   <= '0;
         trcd_q  <= '0;
         tccd_q  <= '0;
         twtr_q  <= '0;
         cmd_q   <= CMD_NOP;
         bank_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         trp_q   <= trp_d;
         trcd_q  <= trcd_d;
         tccd_q  <= tccd_d;
         twtr_q  <= twtr_d;
         cmd_q   <= cmd_d;
         bank_q  <= bank_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_row_q  <= '0;
         req_col_q  <= '0;
         req_data_q <= '0;
         req_idx_q  <= '0;
         req_t_q    <= 1'b0;
         req_bank_q <= '0;
      end else if (w_accept) begin
         req_row_q  <= row_i;
         req_col_q  <= col_i;
         req_data_q <= data_i;
         req_idx_q  <= idx_i;
         req_t_q    <= t_i;
         req_bank_q <= {bg_i, ba_i};
      end
   end

   assign cmd_o    = cmd_q;
   assign cmd_ba_o = bank_q[1:0];
   assign cmd_bg_o = bank_q[3:2];
   assign addr_o   = addr_q;
   assign data_o   = data_q;
   assign idx_o    = idx_q;

endmodule

`default_nettype wire
